mdio_arbiter: RTL and testbench
===============================

Name: mdio_arbiter

Overview:
- Shares one MDIO management master (frame engine producing MDC/MDIO) between NUM_REQ independent requesters, e.g. PHY init sequencer, link-status poller, CPU register bridge.
- Round-robin arbitration over a valid/ready command handshake. One transaction in flight at a time.
- Response watchdog returns an error to the requester if the master never completes.
- Sits between the requester blocks and the MDIO master, all in the 125 MHz system clock domain.

Parameters:
- NUM_REQ, 3, number of requesters (1..8).
- TIMEOUT_CYCLES, 16384, clk cycles allowed in WAIT before abort (>=1; ~131 us at 125 MHz covers a 64-bit frame at 1 Mbps plus margin).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester command valid
- req_ready  output  NUM_REQ  per-requester command accept (one-hot or zero)
- req_write  input  NUM_REQ  1=write, 0=read
- req_phy_addr  input  5*NUM_REQ  PHY address; requester i at bits [5i+4:5i]
- req_reg_addr  input  5*NUM_REQ  register address, same packing
- req_wdata  input  16*NUM_REQ  write data; requester i at bits [16i+15:16i]
- resp_valid  output  NUM_REQ  one-cycle completion pulse to the owning requester
- resp_rdata  output  16  read data (shared; valid with resp_valid)
- resp_error  output  1  timeout flag (shared; valid with resp_valid)
- cmd_valid  output  1  command to master
- cmd_ready  input  1  master accepts command
- cmd_write  output  1  latched opcode
- cmd_phy_addr  output  5  latched PHY address
- cmd_reg_addr  output  5  latched register address
- cmd_wdata  output  16  latched write data
- rsp_valid  input  1  master frame complete (one-cycle pulse)
- rsp_rdata  input  16  master read data, valid with rsp_valid
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first.
  - All registered outputs are 0: cmd_*, resp_valid, resp_rdata, resp_error, busy.
  - Reset mid-transaction aborts silently: cmd_valid drops and no response is issued.
- FSM states:
  - IDLE:
    - winner = first i with req_valid[i], searching from (last_grant+1) mod NUM_REQ upward with wrap.
    - req_ready[winner]=1 combinationally; all other req_ready bits are 0. req_ready is 0 in every other state.
    - On req_valid&req_ready: latch write/phy/reg/wdata into cmd_* regs, last_grant<=winner, owner<=winner, go to ISSUE.
  - ISSUE: cmd_valid=1 with cmd_* held stable. On cmd_ready: cmd_valid<=0, clear timeout counter, go to WAIT.
  - WAIT:
    - Counter increments each cycle.
    - On rsp_valid: resp_rdata<=rsp_rdata, resp_error<=0, go to RESPOND.
    - Else, if counter==TIMEOUT_CYCLES-1: resp_rdata<=16'hFFFF, resp_error<=1, go to RESPOND.
    - rsp_valid on the same cycle as the timeout wins (no error).
  - RESPOND: resp_valid[owner]=1 for exactly one cycle, then IDLE.
- Signals outside their states:
  - rsp_valid outside WAIT is ignored.
  - resp_rdata/resp_error hold their value until the next RESPOND.
- Latency:
  - Accept to cmd_valid: 1 cycle.
  - rsp_valid to resp_valid: 1 cycle.
  - Minimum IDLE-to-IDLE: 4 cycles.
  - Back-to-back accepts are possible one cycle after RESPOND.
- Fairness:
  - A continuously requesting requester waits at most NUM_REQ-1 transactions.
  - NUM_REQ=1 degenerates to pass-through sequencing.
- Width rules:
  - Timeout counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps.
  - last_grant/owner width is max(1,$clog2(NUM_REQ)).
- Requester deasserting req_valid before being accepted is legal; no state change results.

Optional Feature:
- MDIO_ARB_STRICT_PRIO_EN:
  - Defined: requester 0 is strict high priority and always wins in IDLE when req_valid[0]=1. The remaining requesters arbitrate round-robin among themselves; last_grant updates only on grants to requesters 1..NUM_REQ-1.
  - Undefined: plain round-robin across all requesters as above.

Test Plan:
- Single read: req 1 valid, phy=5'h01, reg=5'h18, write=0; master rsp_valid after 70 cycles with rdata=16'h0034 -> req_ready[1] pulse, cmd_valid next cycle with phy 01/reg 18, resp_valid=3'b010 one cycle with rdata 16'h0034 and error 0.
- Round-robin: all three req_valid held high, master answers in 5 cycles -> grants in order 0,1,2,0,1,2; exactly one req_ready and one resp_valid bit ever set.
- Timeout: TIMEOUT_CYCLES=32, master never asserts rsp_valid -> resp_valid pulse exactly 32 cycles after the cmd_ready handshake, with resp_error=1 and rdata=16'hFFFF; next request proceeds normally.
- Backpressure: cmd_ready held low 20 cycles -> cmd_valid and cmd_* stable throughout, no timeout counted, busy=1.
- Reset mid-WAIT: reset low for 2 cycles during WAIT -> cmd_valid=0, busy=0, no resp_valid; a late rsp_valid is ignored; first post-reset grant goes to requester 0.
- With MDIO_ARB_STRICT_PRIO_EN: req0 and req2 held high -> req0 granted every transaction; drop req0 -> req2 granted next.

Source files
------------

// File: rtl/mdio_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdio_arbiter
// Purpose  : Round-robin share of one MDIO frame master among NUM_REQ
//            requesters, with a response watchdog. Optional macro
//            MDIO_ARB_STRICT_PRIO_EN gives requester 0 strict priority.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [5*NUM_REQ-1:0]   req_phy_addr,
    input  logic [5*NUM_REQ-1:0]   req_reg_addr,
    input  logic [16*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [15:0]            resp_rdata,
    output logic                   resp_error,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   cmd_write,
    output logic [4:0]             cmd_phy_addr,
    output logic [4:0]             cmd_reg_addr,
    output logic [15:0]            cmd_wdata,
    input  logic                   rsp_valid,
    input  logic [15:0]            rsp_rdata,
    output logic                   busy
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef MDIO_ARB_STRICT_PRIO_EN
    localparam bit c_STRICT = 1'b1;
`else
    localparam bit c_STRICT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_IDX_W-1:0]   w_winner;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_found;
    logic                 w_timeout;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_cmd_valid;
    logic                 r_cmd_write;
    logic [4:0]           r_cmd_phy;
    logic [4:0]           r_cmd_reg;
    logic [15:0]          r_cmd_wdata;
    logic [15:0]          r_resp_rdata;
    logic                 r_resp_error;

    // Reset asserts immediately but releases two clocks later, glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Search starts just after the last grant and wraps.
    always_comb begin
        w_winner = '0;
        w_cand   = '0;
        w_found  = 1'b0;
        if (c_STRICT && req_valid[0]) begin
            w_found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_cand = c_IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
                if (!w_found && req_valid[w_cand] && !(c_STRICT && w_cand == '0)) begin
                    w_found  = 1'b1;
                    w_winner = w_cand;
                end
            end
        end
    end

    assign w_timeout = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next = S_ISSUE;
            S_ISSUE:   if (cmd_ready) w_next = S_WAIT;
            S_WAIT:    if (rsp_valid || w_timeout) w_next = S_RESPOND;
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_last_grant <= c_IDX_W'(NUM_REQ - 1);
            r_owner      <= '0;
            r_cnt        <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_write  <= 1'b0;
            r_cmd_phy    <= '0;
            r_cmd_reg    <= '0;
            r_cmd_wdata  <= '0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_write <= req_write[w_winner];
                        r_cmd_phy   <= req_phy_addr[5*w_winner +: 5];
                        r_cmd_reg   <= req_reg_addr[5*w_winner +: 5];
                        r_cmd_wdata <= req_wdata[16*w_winner +: 16];
                        r_owner     <= w_winner;
                        // Requester 0 under strict priority leaves the rotation untouched.
                        if (!c_STRICT || w_winner != '0) r_last_grant <= w_winner;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (rsp_valid) begin
                        r_resp_rdata <= rsp_rdata;
                        r_resp_error <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_rdata <= 16'hFFFF;
                        r_resp_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE && w_found) ? (NUM_REQ'(1) << w_winner) : '0;
    assign resp_valid   = (r_state == S_RESPOND) ? (NUM_REQ'(1) << r_owner) : '0;
    assign resp_rdata   = r_resp_rdata;
    assign resp_error   = r_resp_error;
    assign cmd_valid    = r_cmd_valid;
    assign cmd_write    = r_cmd_write;
    assign cmd_phy_addr = r_cmd_phy;
    assign cmd_reg_addr = r_cmd_reg;
    assign cmd_wdata    = r_cmd_wdata;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mdio_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdio_arbiter
// Purpose  : Directed bench for mdio_arbiter; instance a has a long watchdog,
//            instance b a 32-cycle watchdog. Both share every input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid, req_write;
    logic [14:0] req_phy_addr, req_reg_addr;
    logic [47:0] req_wdata;
    logic        cmd_ready, rsp_valid;
    logic [15:0] rsp_rdata;

    logic [2:0]  req_ready_a, resp_valid_a, req_ready_b, resp_valid_b;
    logic [15:0] resp_rdata_a, resp_rdata_b, cmd_wdata_a, cmd_wdata_b;
    logic        resp_error_a, resp_error_b, cmd_valid_a, cmd_valid_b;
    logic        cmd_write_a, cmd_write_b, busy_a, busy_b;
    logic [4:0]  cmd_phy_a, cmd_phy_b, cmd_reg_a, cmd_reg_b;

    bit          use_b;
    logic [2:0]  m_req_ready, m_resp_valid;
    logic [15:0] m_resp_rdata, m_cmd_wdata;
    logic        m_resp_error, m_cmd_valid, m_cmd_write, m_busy;
    logic [4:0]  m_cmd_phy, m_cmd_reg;

    int n_pass  = 0;
    int n_total = 0;

    always #4 clk = ~clk;

    mdio_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(128)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_write(req_write), .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a),
        .resp_error(resp_error_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write_a), .cmd_phy_addr(cmd_phy_a), .cmd_reg_addr(cmd_reg_a),
        .cmd_wdata(cmd_wdata_a), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy_a)
    );

    mdio_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(32)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_write(req_write), .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
        .resp_error(resp_error_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write_b), .cmd_phy_addr(cmd_phy_b), .cmd_reg_addr(cmd_reg_b),
        .cmd_wdata(cmd_wdata_b), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy_b)
    );

    assign m_req_ready  = use_b ? req_ready_b  : req_ready_a;
    assign m_resp_valid = use_b ? resp_valid_b : resp_valid_a;
    assign m_resp_rdata = use_b ? resp_rdata_b : resp_rdata_a;
    assign m_resp_error = use_b ? resp_error_b : resp_error_a;
    assign m_cmd_valid  = use_b ? cmd_valid_b  : cmd_valid_a;
    assign m_cmd_write  = use_b ? cmd_write_b  : cmd_write_a;
    assign m_cmd_phy    = use_b ? cmd_phy_b    : cmd_phy_a;
    assign m_cmd_reg    = use_b ? cmd_reg_b    : cmd_reg_a;
    assign m_cmd_wdata  = use_b ? cmd_wdata_b  : cmd_wdata_a;
    assign m_busy       = use_b ? busy_b       : busy_a;

    typedef struct {
        logic [2:0] valid;
        logic [2:0] ready;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 3'b000;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_ready(input int who);
        #1;
        for (int i = 0; i < 20 && m_req_ready == 3'b000; i++) @(negedge clk);
        check("req_ready", m_req_ready, 32'd1 << who);
    endtask

    // One full transaction: grant, optional backpressure, response after dly WAIT cycles.
    task automatic txn(input int who, input int bp, input int dly, input logic [15:0] rd, input bit drop);
        wait_ready(who);
        @(negedge clk);
        if (drop) req_valid[who] = 1'b0;
        check("cmd_valid_issue", m_cmd_valid, 1);
        check("cmd_phy", m_cmd_phy, req_phy_addr[who*5 +: 5]);
        check("cmd_reg", m_cmd_reg, req_reg_addr[who*5 +: 5]);
        check("cmd_wr_data", {m_cmd_write, m_cmd_wdata}, {req_write[who], req_wdata[who*16 +: 16]});
        check("ready_in_issue", m_req_ready, 0);
        repeat (bp) begin
            @(negedge clk);
            check("bp_hold", {m_busy, m_cmd_valid, m_cmd_phy, m_cmd_reg},
                  {2'b11, req_phy_addr[who*5 +: 5], req_reg_addr[who*5 +: 5]});
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("cmd_valid_wait", {m_busy, m_cmd_valid}, 2'b10);
        repeat (dly - 1) @(negedge clk);
        rsp_valid = 1'b1;
        rsp_rdata = rd;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_rdata = 16'hDEAD;
        check("resp_valid", m_resp_valid, 32'd1 << who);
        check("resp_data", {m_resp_error, m_resp_rdata}, {1'b0, rd});
        @(negedge clk);
        check("resp_one_cycle", m_resp_valid, 0);
    endtask

    initial begin
        int cnt;
        use_b        = 1'b0;
        rsp_rdata    = 16'h0000;
        req_write    = 3'b001;
        req_phy_addr = {5'h1F, 5'h01, 5'h10};
        req_reg_addr = {5'h00, 5'h18, 5'h02};
        req_wdata    = {16'h0000, 16'h0000, 16'hA5A5};
        tbl[0] = '{3'b000, 3'b000};
        tbl[1] = '{3'b001, 3'b001};
        tbl[2] = '{3'b010, 3'b010};
        tbl[3] = '{3'b100, 3'b100};
        tbl[4] = '{3'b110, 3'b010};
        tbl[5] = '{3'b101, 3'b001};
        tbl[6] = '{3'b111, 3'b001};
        tbl[7] = '{3'b011, 3'b001};

        do_reset();
        check("rst_cmd", {cmd_valid_a, cmd_write_a, cmd_phy_a, cmd_reg_a, cmd_wdata_a}, 0);
        check("rst_resp", {busy_a, resp_valid_a, resp_error_a, resp_rdata_a}, 0);

        // Combinational arbitration straight after reset; valid withdrawn before any edge.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = tbl[i].valid;
            #1;
            check("arb_vec", req_ready_a, tbl[i].ready);
            req_valid = 3'b000;
        end

        // Single read from requester 1 answered after 70 cycles.
        req_valid = 3'b010;
        txn(1, 0, 70, 16'h0034, 1'b1);

`ifdef MDIO_ARB_STRICT_PRIO_EN
        do_reset();
        req_valid = 3'b101;
        for (int k = 0; k < 3; k++) txn(0, 0, 5, 16'h2000 + 16'(k), 1'b0);
        req_valid[0] = 1'b0;
        txn(2, 0, 5, 16'h2100, 1'b1);
`else
        do_reset();
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) txn(k % 3, 0, 5, 16'h1000 + 16'(k), 1'b0);
`endif

        // Watchdog on the 32-cycle instance.
        do_reset();
        use_b     = 1'b1;
        req_valid = 3'b001;
        wait_ready(0);
        @(negedge clk);
        req_valid = 3'b000;
        check("to_cmd_valid", cmd_valid_b, 1);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            cnt++;
            #1;
            if (resp_valid_b != 3'b000) break;
        end
        check("timeout_latency", cnt, 32);
        check("timeout_resp", {resp_valid_b, resp_error_b, resp_rdata_b}, {3'b001, 1'b1, 16'hFFFF});
        @(negedge clk);
        req_valid = 3'b010;
        txn(1, 0, 3, 16'h1234, 1'b1);

        // Backpressure: ISSUE time must not feed the watchdog.
        do_reset();
        req_valid = 3'b100;
        txn(2, 20, 20, 16'hBEEF, 1'b1);
        use_b = 1'b0;

        // Reset in the middle of WAIT.
        do_reset();
        req_valid = 3'b100;
        wait_ready(2);
        @(negedge clk);
        req_valid = 3'b000;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy_a, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_state", {cmd_valid_a, busy_a}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rsp_valid = (i == 2);
            rsp_rdata = 16'h5555;
            @(negedge clk);
            check("post_rst_quiet", {busy_a, resp_valid_a, cmd_valid_a}, 0);
        end
        rsp_valid = 1'b0;
        req_valid = 3'b111;
        wait_ready(0);
        req_valid = 3'b000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
